spi_rom_responder: RTL



---
 rtl/spi_rom_pkg.sv | 26 ++
 rtl/spi_edge_sync.sv | 51 +++++
 rtl/spi_rom_responder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rom_pkg.sv
// Shared definitions for the SPI ROM responder: opcodes, phase lengths, FSM states.
// Optional 0Bh FAST READ support is selected in the top level by SPI_ROM_FAST_READ_EN.
package spi_rom_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } spi_state_t;

    // True when the opcode starts a supported read stream.
    function automatic logic cmd_supported(input logic [7:0] op, input logic fast_en);
        return (op == CMD_READ) || (fast_en && (op == CMD_FAST_READ));
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the SPI pins into the clk domain: 2-FF synchronizer per pin followed by
// one edge register. cs and mosi are delayed by the same three stages so that
// cs_s, mosi_s, rise and fall all refer to the same pin instant.
module spi_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_cs,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic cs_s,
    output logic rise,
    output logic fall,
    output logic mosi_s
);

    // bit 0 = cs, bit 1 = sclk, bit 2 = mosi
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic       sclk_last_reg;
    logic       rise_reg;
    logic       fall_reg;
    logic       cs_reg;
    logic       mosi_reg;

    // Synchronizer chain plus the aligned third stage (edge register, edge pulses, delayed cs/mosi).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg      <= 3'b000;
            sync_reg      <= 3'b000;
            sclk_last_reg <= 1'b0;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
            cs_reg        <= 1'b0;
            mosi_reg      <= 1'b0;
        end else begin
            meta_reg      <= {spi_mosi, spi_sclk, spi_cs};
            sync_reg      <= meta_reg;
            sclk_last_reg <= sync_reg[1];
            rise_reg      <= sync_reg[1] & ~sclk_last_reg;
            fall_reg      <= ~sync_reg[1] & sclk_last_reg;
            cs_reg        <= sync_reg[0];
            mosi_reg      <= sync_reg[2];
        end
    end

    assign cs_s   = cs_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;
    assign mosi_s = mosi_reg;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI flash READ (03h) responder streaming bytes from a synchronous ROM port.
// Define SPI_ROM_FAST_READ_EN to also accept FAST READ (0Bh) with 8 dummy clocks.
module spi_rom_responder
    import spi_rom_pkg::*;
#(
    parameter int ROM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_cs,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  rom_rd,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  active,
    output logic                  cmd_err
);

`ifdef SPI_ROM_FAST_READ_EN
    localparam logic FAST_READ_EN = 1'b1;
`else
    localparam logic FAST_READ_EN = 1'b0;
`endif

    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BITS - 1);
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);

    logic cs_s, rise, fall, mosi_s;

    spi_edge_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .cs_s     (cs_s),
        .rise     (rise),
        .fall     (fall),
        .mosi_s   (mosi_s)
    );

    spi_state_t            state_reg, state_next;
    logic [4:0]            bit_cnt_reg, bit_cnt_next;
    logic [7:0]            cmd_reg, cmd_next;
    logic [ROM_ADDR_W-1:0] addr_reg, addr_next;
    logic                  fast_reg, fast_next;
    logic [ROM_ADDR_W-1:0] rom_addr_reg, rom_addr_next;
    logic                  rom_rd_reg, rom_rd_next;
    logic [7:0]            shift_reg, shift_next;
    logic [2:0]            data_cnt_reg, data_cnt_next;
    logic                  miso_reg, miso_next;
    logic                  cmd_err_reg, cmd_err_next;
    logic                  rd_dly_reg;
    logic [7:0]            hold_reg;
    logic                  cs_prev_reg;
    logic [1:0]            fill_reg;

    logic                  cs_start;
    logic [7:0]            cmd_shifted;
    logic [ROM_ADDR_W-1:0] addr_shifted;

    // cs_prev is held high until the synchronizer has refilled after reset, so a cs
    // that was already high across reset does not look like a new transfer.
    assign cs_start     = cs_s & ~cs_prev_reg;
    assign cmd_shifted  = {cmd_reg[6:0], mosi_s};
    // Only the low address bits survive; upper address bits shift out the top.
    assign addr_shifted = {addr_reg[ROM_ADDR_W-2:0], mosi_s};

    // State and datapath registers; hold captures ROM data one clk after each read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            fast_reg     <= 1'b0;
            rom_addr_reg <= '0;
            rom_rd_reg   <= 1'b0;
            shift_reg    <= '0;
            data_cnt_reg <= '0;
            miso_reg     <= 1'b0;
            cmd_err_reg  <= 1'b0;
            rd_dly_reg   <= 1'b0;
            hold_reg     <= '0;
            cs_prev_reg  <= 1'b1;
            fill_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            cmd_reg      <= cmd_next;
            addr_reg     <= addr_next;
            fast_reg     <= fast_next;
            rom_addr_reg <= rom_addr_next;
            rom_rd_reg   <= rom_rd_next;
            shift_reg    <= shift_next;
            data_cnt_reg <= data_cnt_next;
            miso_reg     <= miso_next;
            cmd_err_reg  <= cmd_err_next;
            rd_dly_reg   <= rom_rd_reg;
            if (rd_dly_reg) begin
                hold_reg <= rom_data;
            end
            fill_reg     <= (fill_reg == 2'd3) ? 2'd3 : fill_reg + 2'd1;
            cs_prev_reg  <= (fill_reg == 2'd3) ? cs_s : 1'b1;
        end
    end

    // Next-state and datapath decode; cs deassertion overrides every state.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        cmd_next      = cmd_reg;
        addr_next     = addr_reg;
        fast_next     = fast_reg;
        rom_addr_next = rom_addr_reg;
        rom_rd_next   = 1'b0;
        shift_next    = shift_reg;
        data_cnt_next = data_cnt_reg;
        miso_next     = miso_reg;
        cmd_err_next  = 1'b0;

        if (!cs_s) begin
            state_next    = ST_IDLE;
            bit_cnt_next  = '0;
            data_cnt_next = '0;
            fast_next     = 1'b0;
            miso_next     = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_start) begin
                        state_next = ST_CMD;
                        // sclk may rise in the same clk that cs is first seen
                        if (rise) begin
                            cmd_next     = cmd_shifted;
                            bit_cnt_next = 5'd1;
                        end else begin
                            bit_cnt_next = '0;
                        end
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_next = cmd_shifted;
                        if (bit_cnt_reg == CMD_LAST) begin
                            bit_cnt_next = '0;
                            if (cmd_supported(cmd_shifted, FAST_READ_EN)) begin
                                state_next = ST_ADDR;
                                fast_next  = (cmd_shifted == CMD_FAST_READ);
                            end else begin
                                state_next   = ST_IGNORE;
                                cmd_err_next = 1'b1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_next = addr_shifted;
                        if (bit_cnt_reg == ADDR_LAST) begin
                            // first byte is fetched here, also for the dummy phase
                            bit_cnt_next  = '0;
                            rom_addr_next = addr_shifted;
                            rom_rd_next   = 1'b1;
                            data_cnt_next = 3'd7;
                            state_next    = fast_reg ? ST_DUMMY : ST_DATA;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (bit_cnt_reg == DUMMY_LAST) begin
                            bit_cnt_next = '0;
                            state_next   = ST_DATA;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        if (data_cnt_reg == 3'd7) begin
                            // byte boundary: present the prefetched byte, fetch the next
                            shift_next    = hold_reg;
                            miso_next     = hold_reg[7];
                            data_cnt_next = '0;
                            rom_addr_next = rom_addr_reg + ROM_ADDR_W'(1);
                            rom_rd_next   = 1'b1;
                        end else begin
                            shift_next    = {shift_reg[6:0], 1'b0};
                            miso_next     = shift_reg[6];
                            data_cnt_next = data_cnt_reg + 3'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_next = 1'b0;
                end
                default: begin
                    state_next = ST_IDLE;
                    miso_next  = 1'b0;
                end
            endcase
        end
    end

    assign spi_miso = miso_reg;
    assign rom_rd   = rom_rd_reg;
    assign rom_addr = rom_addr_reg;
    assign cmd_err  = cmd_err_reg;
    assign active   = (state_reg != ST_IDLE);

endmodule
